arm_multicycle_ctrl: RTL and testbench



---
 rtl/arm_mc_pkg.sv | 63 ++++++
 rtl/arm_multicycle_ctrl_if.sv | 28 ++
 rtl/arm_multicycle_ctrl_cond_unit.sv | 53 +++++
 rtl/arm_multicycle_ctrl.sv | 144 ++++++++++++++
 tb/tb_arm_multicycle_ctrl.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/arm_mc_pkg.sv
// Shared encodings for the multicycle ARM controller: FSM states, mux selects,
// ALU operations, condition codes and the data-processing cmd decoder.
package arm_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXECR,
    S_EXECI,
    S_ALUWB,
    S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;

  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;
  localparam logic [3:0] COND_CS = 4'b0010;
  localparam logic [3:0] COND_CC = 4'b0011;
  localparam logic [3:0] COND_MI = 4'b0100;
  localparam logic [3:0] COND_PL = 4'b0101;
  localparam logic [3:0] COND_VS = 4'b0110;
  localparam logic [3:0] COND_VC = 4'b0111;
  localparam logic [3:0] COND_HI = 4'b1000;
  localparam logic [3:0] COND_LS = 4'b1001;
  localparam logic [3:0] COND_GE = 4'b1010;
  localparam logic [3:0] COND_LT = 4'b1011;
  localparam logic [3:0] COND_GT = 4'b1100;
  localparam logic [3:0] COND_LE = 4'b1101;
  localparam logic [3:0] COND_AL = 4'b1110;

  // Returns {NoWrite, ALUControl}; unknown cmds behave as a non-writing ADD.
  function automatic logic [3:0] decode_cmd(input logic [3:0] cmd);
    case (cmd)
      4'b0100: decode_cmd = {1'b0, ALU_ADD};
      4'b0010: decode_cmd = {1'b0, ALU_SUB};
      4'b0000: decode_cmd = {1'b0, ALU_AND};
      4'b1100: decode_cmd = {1'b0, ALU_ORR};
      4'b1010: decode_cmd = {1'b1, ALU_SUB};
      default: decode_cmd = {1'b1, ALU_ADD};
    endcase
  endfunction

endpackage

// File: rtl/arm_multicycle_ctrl_if.sv
// Instruction/flag inputs and datapath control outputs of the controller.
interface arm_multicycle_ctrl_if;
  logic [31:12] Instr;
  logic [3:0]   ALUFlags;
  logic         PCWrite;
  logic         MemWrite;
  logic         RegWrite;
  logic         IRWrite;
  logic         AdrSrc;
  logic         ALUSrcA;
  logic [1:0]   ALUSrcB;
  logic [1:0]   ResultSrc;
  logic [1:0]   ImmSrc;
  logic [1:0]   RegSrc;
  logic [2:0]   ALUControl;

  modport master (
    output Instr, ALUFlags,
    input  PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );

  modport slave (
    input  Instr, ALUFlags,
    output PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, ALUSrcA,
           ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl
  );
endinterface

// File: rtl/arm_multicycle_ctrl_cond_unit.sv
// Flags register {N,Z,C,V} plus the CondEx bit captured once per instruction in DECODE.
module cond_unit
  import arm_mc_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [3:0] alu_flags,
  input  logic       condex_latch,
  input  logic       flags_load,
  output logic       condex
);

  logic [3:0] flags;
  logic       cond_ok;
  logic       n, z, c, v;

  assign {n, z, c, v} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      COND_EQ: cond_ok = z;
      COND_NE: cond_ok = ~z;
      COND_CS: cond_ok = c;
      COND_CC: cond_ok = ~c;
      COND_MI: cond_ok = n;
      COND_PL: cond_ok = ~n;
      COND_VS: cond_ok = v;
      COND_VC: cond_ok = ~v;
      COND_HI: cond_ok = c & ~z;
      COND_LS: cond_ok = ~c | z;
      COND_GE: cond_ok = (n == v);
      COND_LT: cond_ok = (n != v);
      COND_GT: cond_ok = ~z & (n == v);
      COND_LE: cond_ok = z | (n != v);
      COND_AL: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end

  // Flags only move for executed S-suffixed data-processing instructions.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flags  <= 4'b0000;
      condex <= 1'b0;
    end else begin
      if (condex_latch) condex <= cond_ok;
      if (flags_load && condex) flags <= alu_flags;
    end
  end

endmodule

// File: rtl/arm_multicycle_ctrl.sv
// Multicycle ARM control FSM: Moore datapath controls, write strobes gated by CondEx.
// While rst is low every write strobe is forced low and the muxes show FETCH settings.
module arm_multicycle_ctrl
  import arm_mc_pkg::*;
(
  input logic clk,
  input logic rst,
  arm_multicycle_ctrl_if.slave bus
);

  state_t     state_q, state_d;
  logic [1:0] op;
  logic [5:0] funct;
  logic [3:0] cond, rd;
  logic       condex, nowrite;
  logic [2:0] dp_alu;
  logic       unused_rn;

  logic       pc_w, mem_w, reg_w, ir_w, adr_src, src_a;
  logic [1:0] src_b, res_src;
  logic [2:0] alu_ctl;

  assign cond      = bus.Instr[31:28];
  assign op        = bus.Instr[27:26];
  assign funct     = bus.Instr[25:20];
  assign rd        = bus.Instr[15:12];
  assign unused_rn = ^bus.Instr[19:16];

  assign {nowrite, dp_alu} = decode_cmd(funct[4:1]);

  cond_unit u_cond (
    .clk          (clk),
    .rst          (rst),
    .cond         (cond),
    .alu_flags    (bus.ALUFlags),
    .condex_latch (state_q == S_DECODE),
    .flags_load   (((state_q == S_EXECR) || (state_q == S_EXECI)) && funct[0]),
    .condex       (condex)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pc_w    = 1'b0;
    mem_w   = 1'b0;
    reg_w   = 1'b0;
    ir_w    = 1'b0;
    adr_src = 1'b0;
    src_a   = 1'b0;
    src_b   = SRCB_REG;
    res_src = RES_ALUOUT;
    alu_ctl = ALU_ADD;
    case (state_q)
      S_FETCH: begin
        ir_w    = 1'b1;
        pc_w    = 1'b1;
        src_a   = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RES_ALURESULT;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        src_a   = 1'b1;
        src_b   = SRCB_FOUR;
        res_src = RES_ALURESULT;
        case (op)
          OP_MEM:  state_d = S_MEMADR;
          OP_DP:   state_d = funct[5] ? S_EXECI : S_EXECR;
          OP_BR:   state_d = S_BRANCH;
          default: state_d = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        src_b   = SRCB_IMM;
        state_d = funct[0] ? S_MEMRD : S_MEMWR;
      end
      S_MEMRD: begin
        adr_src = 1'b1;
        state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_src = RES_DATA;
        reg_w   = condex;
        pc_w    = condex && (rd == 4'hF);
        state_d = S_FETCH;
      end
      S_MEMWR: begin
        adr_src = 1'b1;
        mem_w   = condex;
        state_d = S_FETCH;
      end
      S_EXECR: begin
        alu_ctl = dp_alu;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        src_b   = SRCB_IMM;
        alu_ctl = dp_alu;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        reg_w   = condex && !nowrite;
        pc_w    = condex && (rd == 4'hF);
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        src_b   = SRCB_IMM;
        res_src = RES_ALURESULT;
        pc_w    = condex;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    if (!rst) begin
      pc_w    = 1'b0;
      mem_w   = 1'b0;
      reg_w   = 1'b0;
      ir_w    = 1'b0;
      adr_src = 1'b0;
      src_a   = 1'b1;
      src_b   = SRCB_FOUR;
      res_src = RES_ALURESULT;
      alu_ctl = ALU_ADD;
    end
  end

  assign bus.PCWrite    = pc_w;
  assign bus.MemWrite   = mem_w;
  assign bus.RegWrite   = reg_w;
  assign bus.IRWrite    = ir_w;
  assign bus.AdrSrc     = adr_src;
  assign bus.ALUSrcA    = src_a;
  assign bus.ALUSrcB    = src_b;
  assign bus.ResultSrc  = res_src;
  assign bus.ALUControl = alu_ctl;
  assign bus.ImmSrc     = op;
  assign bus.RegSrc     = {(op == OP_MEM) && !funct[0], op == OP_BR};

endmodule

// File: tb/tb_arm_multicycle_ctrl.sv
// Bench for arm_multicycle_ctrl: directed instruction cases plus random instruction
// streams with occasional resets, all checked against a phase-list reference model.
module tb_arm_multicycle_ctrl;

  localparam int PF = 0, PD = 1, PMA = 2, PMR = 3, PMWB = 4, PMW = 5, PEX = 6, PAWB = 7, PB = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  logic [3:0] m_flags = 4'b0000;
  logic       m_ce = 1'b0;

  arm_multicycle_ctrl_if bus ();
  arm_multicycle_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic bit cond_ok(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'd0: return z;        4'd1: return !z;
      4'd2: return cy;       4'd3: return !cy;
      4'd4: return n;        4'd5: return !n;
      4'd6: return v;        4'd7: return !v;
      4'd8: return cy && !z; 4'd9: return !cy || z;
      4'd10: return n == v;  4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Expected outputs for one cycle of a given phase; mux fields are only checked
  // in phases where their value matters.
  task automatic check_outputs(input int ph, input logic [19:0] ins, input bit in_rst);
    logic [1:0] op = ins[15:14];
    logic [5:0] fn = ins[13:8];
    bit rd15 = (ins[3:0] == 4'hF);
    int alu = 0;
    bit nw = 0;
    int e_pc = 0, e_mem = 0, e_reg = 0, e_ir = 0;
    int e_adr = -1, e_sa = -1, e_sb = -1, e_res = -1, e_alu = -1;
    case (fn[4:1])
      4'b0100: begin alu = 0; nw = 0; end
      4'b0010: begin alu = 1; nw = 0; end
      4'b0000: begin alu = 2; nw = 0; end
      4'b1100: begin alu = 3; nw = 0; end
      4'b1010: begin alu = 1; nw = 1; end
      default: begin alu = 0; nw = 1; end
    endcase
    case (in_rst ? PF : ph)
      PF: begin e_ir = 1; e_pc = 1; e_adr = 0; e_sa = 1; e_sb = 2; e_alu = 0; e_res = 2; end
      PD: begin e_sa = 1; e_sb = 2; e_alu = 0; e_res = 2; end
      PMA: begin e_sa = 0; e_sb = 1; e_alu = 0; end
      PMR: e_adr = 1;
      PMWB: begin e_res = 1; e_reg = m_ce; e_pc = m_ce && rd15; end
      PMW: begin e_adr = 1; e_mem = m_ce; end
      PEX: begin e_sa = 0; e_sb = fn[5] ? 1 : 0; e_alu = alu; end
      PAWB: begin e_res = 0; e_reg = m_ce && !nw; e_pc = m_ce && rd15; end
      PB: begin e_sa = 0; e_sb = 1; e_alu = 0; e_res = 2; e_pc = m_ce; end
      default: ;
    endcase
    if (in_rst) begin e_ir = 0; e_pc = 0; end
    chk($sformatf("ph%0d PCWrite", ph), bus.PCWrite, e_pc);
    chk($sformatf("ph%0d MemWrite", ph), bus.MemWrite, e_mem);
    chk($sformatf("ph%0d RegWrite", ph), bus.RegWrite, e_reg);
    chk($sformatf("ph%0d IRWrite", ph), bus.IRWrite, e_ir);
    chk($sformatf("ph%0d ImmSrc", ph), bus.ImmSrc, op);
    chk($sformatf("ph%0d RegSrc", ph), bus.RegSrc,
        {30'd0, (op == 2'b01) && !fn[0], op == 2'b10});
    if (e_adr >= 0) chk($sformatf("ph%0d AdrSrc", ph), bus.AdrSrc, e_adr);
    if (e_sa >= 0)  chk($sformatf("ph%0d ALUSrcA", ph), bus.ALUSrcA, e_sa);
    if (e_sb >= 0)  chk($sformatf("ph%0d ALUSrcB", ph), bus.ALUSrcB, e_sb);
    if (e_res >= 0) chk($sformatf("ph%0d ResultSrc", ph), bus.ResultSrc, e_res);
    if (e_alu >= 0) chk($sformatf("ph%0d ALUControl", ph), bus.ALUControl, e_alu);
  endtask

  // Runs one instruction from FETCH; fl < 0 means random ALUFlags each cycle.
  // rst_at names the phase index during which rst is held low (aborting the instruction).
  task automatic do_instr(input logic [19:0] ins, input int fl, input int rst_at,
                          output int ncyc, output int regw, output int memw, output int pcw_last);
    int ph[$];
    logic [1:0] op = ins[15:14];
    logic [5:0] fn = ins[13:8];
    ph.push_back(PF);
    ph.push_back(PD);
    case (op)
      2'b00: begin ph.push_back(PEX); ph.push_back(PAWB); end
      2'b01: begin
        ph.push_back(PMA);
        if (fn[0]) begin ph.push_back(PMR); ph.push_back(PMWB); end
        else ph.push_back(PMW);
      end
      2'b10: ph.push_back(PB);
      default: ;
    endcase
    ncyc = 0; regw = 0; memw = 0; pcw_last = 0;
    for (int i = 0; i < ph.size(); i++) begin
      bus.Instr    = ins;
      bus.ALUFlags = (fl < 0) ? 4'($urandom) : 4'(fl);
      rst          = (i == rst_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      check_outputs(ph[i], ins, !rst);
      ncyc++;
      regw += int'(bus.RegWrite);
      memw += int'(bus.MemWrite);
      pcw_last = int'(bus.PCWrite);
      @(posedge clk);
      if (!rst) begin
        m_flags = 4'b0000;
        m_ce    = 1'b0;
        #1 rst = 1'b1;
        return;
      end
      if (ph[i] == PD) m_ce = cond_ok(ins[19:16], m_flags);
      if (ph[i] == PEX && fn[0] && m_ce) m_flags = bus.ALUFlags;
      #1;
    end
  endtask

  initial begin
    int n, rw, mw, pw;
    logic [19:0] ins;

    bus.Instr    = 20'h0;
    bus.ALUFlags = 4'h0;
    rst          = 1'b0;
    repeat (2) begin
      @(negedge clk);
      check_outputs(PF, bus.Instr, 1'b1);
    end
    @(posedge clk);
    #1 rst = 1'b1;

    do_instr(20'hE2821, 0, -1, n, rw, mw, pw);
    chk("ADD cycles", n, 4);
    chk("ADD RegWrite count", rw, 1);

    do_instr(20'hE5910, 0, -1, n, rw, mw, pw);
    chk("LDR cycles", n, 5);
    chk("LDR RegWrite count", rw, 1);

    do_instr(20'hE5810, 0, -1, n, rw, mw, pw);
    chk("STR cycles", n, 4);
    chk("STR MemWrite count", mw, 1);
    chk("STR RegSrc", bus.RegSrc, 2);

    do_instr(20'hE2500, 4'b0100, -1, n, rw, mw, pw);
    do_instr(20'h0A000, 0, -1, n, rw, mw, pw);
    chk("BEQ taken cycles", n, 3);
    chk("BEQ taken PCWrite", pw, 1);

    do_instr(20'hE2500, 4'b0000, -1, n, rw, mw, pw);
    do_instr(20'h0A000, 0, -1, n, rw, mw, pw);
    chk("BEQ not-taken cycles", n, 3);
    chk("BEQ not-taken PCWrite", pw, 0);

    do_instr(20'hE3500, 4'b0100, -1, n, rw, mw, pw);
    chk("CMP RegWrite count", rw, 0);
    chk("CMP model flags", m_flags, 4'b0100);
    chk("CMP dut flags", dut.u_cond.flags, 4'b0100);

    do_instr(20'hE2500, 4'b1001, -1, n, rw, mw, pw);
    chk("SUBS dut flags", dut.u_cond.flags, 4'b1001);
    do_instr(20'hE5810, 0, 3, n, rw, mw, pw);
    chk("reset-in-MEMWR MemWrite", mw, 0);
    chk("reset-in-MEMWR dut flags", dut.u_cond.flags, 4'b0000);
    chk("reset-in-MEMWR model flags", m_flags, 4'b0000);
    do_instr(20'hE2821, 0, -1, n, rw, mw, pw);
    chk("post-reset ADD cycles", n, 4);

    for (int k = 0; k < 400; k++) begin
      ins = 20'($urandom);
      if ($urandom_range(0, 3) == 0) ins[19:16] = 4'hE;
      if ($urandom_range(0, 7) == 0) ins[3:0] = 4'hF;
      do_instr(ins, -1, ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 4)) : -1,
               n, rw, mw, pw);
      chk("random flags", dut.u_cond.flags, m_flags);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
